// File: rtl/ram_sync_param_if.sv
// Bus between the CPU address/data registers and the parametrised data RAM.
interface ram_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              write;
  logic              read;
  logic              clear_req;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              addr_err;

  modport master (
    output write, read, clear_req, address, data_in,
    input  data_out, busy, addr_err
  );

  modport slave (
    input  write, read, clear_req, address, data_in,
    output data_out, busy, addr_err
  );
endinterface

// File: rtl/ram_sync_param.sv
// Single-port data RAM with a clear sequencer that rewrites every word after
// reset or on request, plus out-of-range access detection.
module ram_sync_param #(
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 96,
  parameter int              ADDR_W    = 7,
  parameter int              READ_LAT  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00,
  parameter logic [DATA_W-1:0] PRESET0   = 8'h33,
  parameter logic [DATA_W-1:0] PRESET1   = 8'h22
) (
  input  logic            clk,
  input  logic            reset,
  ram_sync_param_if.slave bus
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic              RD_USED = (READ_LAT == 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] clear_word;

  assign in_range = {1'b0, bus.address} < DEPTH_W;
  assign bus.busy = (state == CLEAR);

  // The sequencer owns the write port while clearing; reset suppresses it so
  // word 0 is first written on the edge after reset is released.
  always_comb begin
    clear_word = CLEAR_VAL;
    if (ptr == '0)
      clear_word = PRESET0;
    else if (ptr == ADDR_W'(1))
      clear_word = PRESET1;
    mem_we = 1'b0;
    waddr  = bus.address;
    wdata  = bus.data_in;
    if (state == CLEAR) begin
      mem_we = !reset;
      waddr  = ptr;
      wdata  = clear_word;
    end else if (bus.write && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CLEAR;
      ptr          <= '0;
      bus.addr_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          bus.addr_err <= 1'b0;
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        IDLE: begin
          bus.addr_err <= !in_range && (bus.write || (RD_USED && bus.read));
          if (bus.clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  // Registered read samples mem before this edge's write lands: read-first.
  if (READ_LAT == 1) begin : g_reg_read
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        rd_q <= '0;
      else if (state == IDLE && bus.read)
        rd_q <= in_range ? mem[bus.address] : '0;
    end
    assign bus.data_out = rd_q;
  end else begin : g_comb_read
    assign bus.data_out = (state == IDLE && in_range) ? mem[bus.address] : '0;
  end

endmodule
